// File: rtl/arb_pkg.sv
// Shared arbitration types: hold FSM states, 4-bit request vector, one-hot test.
package arb_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, COOL} hold_state_t;

    typedef logic [3:0] req_vec_t;

    function automatic logic is_onehot4(input req_vec_t v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/grant_hold4_if.sv
// Request/grant bundle between the parent (master) and grant_hold4 (slave).
interface grant_hold4_if
    import arb_pkg::*;
#(
    parameter int CW = 4
) ();

    req_vec_t        req;
    logic            en;
    req_vec_t        req_masked;
    req_vec_t        gnt_in;
    req_vec_t        gnt_out;
    logic            busy;
    logic [CW-1:0]   hold_cnt;
    logic            err;

    modport master (
        output req, en, gnt_in,
        input  req_masked, gnt_out, busy, hold_cnt, err
    );

    modport slave (
        input  req, en, gnt_in,
        output req_masked, gnt_out, busy, hold_cnt, err
    );

endinterface

// File: rtl/ps4.sv
// 4-bit fixed-priority selector, bit 3 wins; all-zero grant when disabled.
module ps4
    import arb_pkg::*;
(
    input  req_vec_t req,
    input  logic     en,
    output req_vec_t gnt
);

    always_comb begin
        gnt = 4'b0000;
        if (en) begin
            if (req[3])      gnt = 4'b1000;
            else if (req[2]) gnt = 4'b0100;
            else if (req[1]) gnt = 4'b0010;
            else if (req[0]) gnt = 4'b0001;
        end
    end

endmodule

// File: rtl/grant_hold4.sv
// Grant holder around ps4: registers the winner, holds while it requests,
// forces release after MAX_HOLD cycles and masks the old owner for one cycle.
module grant_hold4
    import arb_pkg::*;
#(
    parameter  int MAX_HOLD = 8,
    localparam int CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic          clock,
    input  logic          reset,
    grant_hold4_if.slave  bus
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_HOLD);
    localparam logic [CW-1:0] ONE_CNT = CW'(1);

    hold_state_t   state_q, state_d;
    req_vec_t      gnt_out_q, gnt_out_d;
    req_vec_t      gnt_last_q, gnt_last_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    req_vec_t      block_mask;

    assign block_mask     = (state_q == COOL) ? gnt_last_q : 4'b0000;
    assign bus.req_masked = bus.req & ~block_mask;

    always_comb begin
        state_d    = state_q;
        gnt_out_d  = gnt_out_q;
        gnt_last_d = gnt_last_q;
        hold_cnt_d = hold_cnt_q;
        err_d      = err_q;
        case (state_q)
            HOLD: begin
                // Voluntary drop is checked before the hold limit.
                if (!bus.en || ((bus.req & gnt_out_q) == 4'b0000)) begin
                    state_d    = IDLE;
                    gnt_out_d  = 4'b0000;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == MAX_CNT) begin
                    state_d    = COOL;
                    gnt_last_d = gnt_out_q;
                    gnt_out_d  = 4'b0000;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + ONE_CNT;
                end
            end
            default: begin
                if ((bus.gnt_in != 4'b0000) && !is_onehot4(bus.gnt_in)) begin
                    err_d = 1'b1;
                end
                if (bus.en && is_onehot4(bus.gnt_in)) begin
                    state_d    = HOLD;
                    gnt_out_d  = bus.gnt_in;
                    hold_cnt_d = ONE_CNT;
                end else begin
                    state_d    = IDLE;
                    gnt_out_d  = 4'b0000;
                    hold_cnt_d = '0;
                end
            end
        endcase
        busy_d = (state_d == HOLD);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_out_q  <= 4'b0000;
            gnt_last_q <= 4'b0000;
            hold_cnt_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_out_q  <= gnt_out_d;
            gnt_last_q <= gnt_last_d;
            hold_cnt_q <= hold_cnt_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign bus.gnt_out  = gnt_out_q;
    assign bus.busy     = busy_q;
    assign bus.hold_cnt = hold_cnt_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_grant_hold4.sv
// Randomized bench for grant_hold4 + ps4 against an owner/run-length model.
module tb_grant_hold4;
    import arb_pkg::*;

    localparam int MH = 4;
    localparam int CW = $clog2(MH + 1);

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    logic     frc = 1'b0;
    req_vec_t frc_val = 4'b0000;
    req_vec_t ps4_gnt;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: owner index (-1 none), run length, banned index (-1 none), sticky error.
    int owner  = -1;
    int run    = 0;
    int banned = -1;
    bit err_m  = 1'b0;

    always #5 clk = ~clk;

    grant_hold4_if #(.CW(CW)) bus ();

    ps4 u_ps4 (
        .req (bus.req_masked),
        .en  (bus.en),
        .gnt (ps4_gnt)
    );

    assign bus.gnt_in = frc ? frc_val : ps4_gnt;

    grant_hold4 #(.MAX_HOLD(MH)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL cyc=%0d %s got=%0h exp=%0h", cyc, tag, got, exp);
        end
    endtask

    function automatic logic [3:0] onehot_of(input int idx);
        logic [3:0] v;
        v = 4'b0000;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    task automatic step(input bit r, input logic [3:0] rq, input bit e,
                        input bit f, input logic [3:0] fv);
        logic [3:0] mask_exp;
        logic [3:0] gin;
        int         win;
        int         ones;
        int         idx;

        @(negedge clk);
        rst     = r;
        bus.req = rq;
        bus.en  = e;
        frc     = f;
        frc_val = fv;
        #1;
        mask_exp = rq & ~onehot_of(banned);
        check("req_masked", 32'(bus.req_masked), 32'(mask_exp));

        // Winner the selector should pick this cycle, or the forced value.
        win = -1;
        if (e) begin
            for (int i = 3; i >= 0; i--) begin
                if (win < 0 && rq[i] && i != banned) win = i;
            end
        end
        gin = f ? fv : onehot_of(win);

        if (r) begin
            owner = -1; run = 0; banned = -1; err_m = 1'b0;
        end else if (owner >= 0) begin
            if (!e || !rq[owner]) begin
                owner = -1; run = 0; banned = -1;
            end else if (run == MH) begin
                banned = owner; owner = -1; run = 0;
            end else begin
                run++;
            end
        end else begin
            ones = 0; idx = -1;
            for (int i = 0; i < 4; i++) begin
                if (gin[i]) begin ones++; idx = i; end
            end
            if (ones > 1) err_m = 1'b1;
            banned = -1;
            if (e && ones == 1) begin
                owner = idx; run = 1;
            end else begin
                owner = -1; run = 0;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        check("gnt_out",  32'(bus.gnt_out),  32'(onehot_of(owner)));
        check("busy",     32'(bus.busy),     32'(owner >= 0));
        check("hold_cnt", 32'(bus.hold_cnt), 32'(run));
        check("err",      32'(bus.err),      32'(err_m));
        $display("cyc=%0d rst=%0b en=%0b req=%b gin=%b gnt_out=%b busy=%0b cnt=%0d err=%0b",
                 cyc, r, e, rq, gin, bus.gnt_out, bus.busy, bus.hold_cnt, bus.err);
    endtask

    initial begin
        logic [3:0] rq;
        bit         e;
        int         len;

        bus.req = 4'b0000;
        bus.en  = 1'b0;

        // Reset with everyone requesting, then first grant to bit 3.
        repeat (2) step(1, 4'b1111, 1, 0, 4'b0000);
        repeat (3) step(0, 4'b1111, 1, 0, 4'b0000);

        // Voluntary release.
        step(1, 4'b0000, 1, 0, 4'b0000);
        repeat (3) step(0, 4'b0100, 1, 0, 4'b0000);
        repeat (2) step(0, 4'b0000, 1, 0, 4'b0000);

        // Forced release and cooldown hand-off.
        step(1, 4'b0000, 1, 0, 4'b0000);
        repeat (14) step(0, 4'b1010, 1, 0, 4'b0000);

        // Drop at the limit goes to IDLE, no mask afterwards.
        step(1, 4'b0000, 1, 0, 4'b0000);
        repeat (4) step(0, 4'b1000, 1, 0, 4'b0000);
        step(0, 4'b0000, 1, 0, 4'b0000);
        repeat (2) step(0, 4'b1111, 1, 0, 4'b0000);

        // Enable drop mid-hold.
        step(1, 4'b0000, 1, 0, 4'b0000);
        repeat (2) step(0, 4'b1111, 1, 0, 4'b0000);
        step(0, 4'b1111, 0, 0, 4'b0000);
        repeat (2) step(0, 4'b1111, 1, 0, 4'b0000);

        // Illegal grant in IDLE: sticky error until reset.
        step(1, 4'b0000, 1, 0, 4'b0000);
        step(0, 4'b0000, 1, 0, 4'b0000);
        step(0, 4'b0110, 1, 1, 4'b0110);
        repeat (6) step(0, 4'b0011, 1, 0, 4'b0000);
        step(1, 4'b0011, 1, 0, 4'b0000);

        // Reset during cooldown.
        repeat (5) step(0, 4'b1001, 1, 0, 4'b0000);
        step(1, 4'b1001, 1, 0, 4'b0000);
        repeat (2) step(0, 4'b1001, 1, 0, 4'b0000);

        // Random bursts with held request patterns.
        for (int k = 0; k < 80; k++) begin
            rq  = 4'($urandom);
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++) begin
                e = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 4) == 0) rq = 4'($urandom);
                if ($urandom_range(0, 39) == 0)
                    step(0, rq, e, 1, 4'($urandom));
                else
                    step(($urandom_range(0, 59) == 0), rq, e, 0, 4'b0000);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/grant_hold4.md
Name: grant_hold4

Overview:
- Sequential wrapper around the 4-bit priority selector (ps4); sits on both sides of it.
- Upstream: produces the masked request vector that drives ps4's req input.
- Downstream: consumes ps4's one-hot gnt, registers it and holds ownership while the winner keeps requesting.
- Enforces a maximum hold time, then a one-cycle cooldown during which the previous owner is masked, so higher-priority requesters cannot starve lower ones indefinitely.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one requester may own the grant (legal range 1..255).
- CW, $clog2(MAX_HOLD+1), width of hold_cnt (derived; not overridden).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  4  raw request vector, bit 3 highest priority.
- en  in  1  global enable; also passed through to ps4.
- req_masked  out  4  combinational: req & ~block_mask; drives ps4 req.
- gnt_in  in  4  ps4 gnt output (expected one-hot or zero).
- gnt_out  out  4  registered one-hot grant to consumers.
- busy  out  1  registered; 1 when state==HOLD.
- hold_cnt  out  CW  registered; cycles the current owner has held gnt_out.
- err  out  1  registered sticky flag; set when gnt_in is non-zero and not one-hot while sampled.

Behaviour:
- Clock and reset (already decided): one clock `clock`; reset `reset` is synchronous, active-high.
- Reset values: state=IDLE, gnt_out=0000, busy=0, hold_cnt=0, err=0, block_mask=0000.
- Reset mid-operation: same values on the next edge regardless of state; the cooldown mask is dropped.
- States: IDLE, HOLD, COOL.
- block_mask = gnt_last when state==COOL, else 0000. gnt_last is the owner at forced release.
- Sampling gnt_in, IDLE or COOL:
  - en=1 and gnt_in one-hot: next state HOLD, gnt_out<=gnt_in, hold_cnt<=1.
  - en=0 or gnt_in=0000: next state IDLE, gnt_out<=0000.
- Illegal gnt_in (popcount>1): treated as 0000 and err<=1. err clears only on reset.
- gnt_in is ignored in HOLD.
- HOLD: let owner = gnt_out. Checks are evaluated in this order:
  1. en=0 or (req & owner)==0 → IDLE, gnt_out<=0000, hold_cnt<=0. Voluntary drop takes precedence over the limit.
  2. Otherwise hold_cnt==MAX_HOLD → COOL, gnt_last<=owner, gnt_out<=0000, hold_cnt<=0.
  3. Otherwise stay in HOLD, hold_cnt<=hold_cnt+1.
- Latency and bubbles:
  - Grant latency is 1 cycle from gnt_in valid to gnt_out.
  - Every release produces at least one cycle with gnt_out=0000; no back-to-back owner switch without a bubble.
- COOL lasts exactly one cycle:
  - The masked owner cannot win during it. Another requester winning via ps4 goes straight to HOLD.
  - If nobody else wins, the state goes to IDLE and the mask clears.
  - The old owner can then win again the following cycle.
- MAX_HOLD=1: the owner holds for 1 cycle, then COOL.
- hold_cnt never exceeds MAX_HOLD and never wraps.
- busy == (state==HOLD); gnt_out is non-zero iff busy.
- en drop in any state → IDLE with gnt_out=0000 on the next edge.
- req_masked honours en only via ps4; it is not gated by en.

Decomposition:
- Shared package `arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, HOLD, COOL} hold_state_t`
  - `typedef logic [3:0] req_vec_t`
  - a `function is_onehot4`
- No sub-module inside grant_hold4. ps4 is instantiated alongside it at the parent level, wired req_masked→ps4.req and ps4.gnt→gnt_in.
- The bench instantiates both blocks together.

Test Plan:
- Reset held 2 cycles with req=1111, en=1 → gnt_out=0000, busy=0, hold_cnt=0, err=0 throughout; first grant gnt_out=1000 one cycle after reset drops.
- Voluntary release: req=0100 for 3 cycles, then 0000 → gnt_out=0100 with hold_cnt 1,2,3; next edge gnt_out=0000, state IDLE.
- Forced release with MAX_HOLD=4, req=1010 constant:
  - gnt_out=1000 for 4 cycles.
  - Then COOL with req_masked=0010.
  - Next edge gnt_out=0010.
  - After 4 more cycles, 1000 wins again after one bubble.
- Priority vs. limit: at hold_cnt==MAX_HOLD drop req of the owner → state IDLE (not COOL), block_mask stays 0000.
- en=0 mid-HOLD with req=1111 → gnt_out=0000 next edge. en back to 1 → gnt_out=1000 one cycle later, hold_cnt=1.
- Force gnt_in=0110 in IDLE with en=1 → err=1, gnt_out=0000; err remains 1 until reset.
